alu_flag_stage: RTL

- Consumer stage placed directly after the combinational ALU operation modules (OR, AND, ADD, SUB, …).
- Registers each ALU result through a valid/ready pipeline stage with a one-entry skid buffer.
- Derives and holds the architectural NZCV flags when the instruction requests a flag update.
- Evaluates the 4-bit ARM-style condition code against the held flags for conditional execution.

---
 rtl/alu_flag_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_flag_stage.sv
// Output stage for the ALU result path: a valid/ready register with a one-entry skid buffer,
// the held NZCV flags, and the ARM-style condition-code evaluation against those flags.
module alu_flag_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_logical,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       flags_nzcv,
  input  logic             flags_wr_en,
  input  logic [3:0]       flags_wr_data,
  input  logic [3:0]       cond,
  output logic             cond_pass
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic [3:0]       flags_q, flags_d;

  logic accept;
  logic xfer;
  logic flag_n, flag_z, flag_c, flag_v;

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready = ~skid_valid_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    flags_d       = flags_q;

    if (!out_valid_q || xfer) begin
      // Output register is free this cycle; the skid entry is older, so it goes first.
      if (skid_valid_q) begin
        out_result_d = skid_result_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_result_d = in_result;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (accept) begin
      skid_result_d = in_result;
      skid_valid_d  = 1'b1;
    end

    if (flags_wr_en) begin
      flags_d = flags_wr_data;
    end else if (accept && in_set_flags) begin
      flags_d[3] = in_result[WIDTH-1];
      flags_d[2] = (in_result == '0);
      flags_d[1] = in_carry;
      flags_d[0] = in_logical ? flags_q[0] : in_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      flags_q       <= 4'b0000;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      flags_q       <= flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign flags_nzcv = flags_q;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  always_comb begin
    cond_pass = 1'b1;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end

endmodule
